// File: rtl/led_arb_pkg.sv
// Shared types and width helpers for the LED bank arbiter.
package led_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      OWN     = 2'd1,
      HANDOFF = 2'd2
   } state_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int v = n - 1; v > 0; v = v >> 1) r++;
      return r;
   endfunction

   // Counter/index width that never collapses to zero bits.
   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : clog2(n);
   endfunction

endpackage

// File: rtl/led_arb_rrpick.sv
// Combinational round-robin picker: first asserted request after 'last', wrapping.
module led_arb_rrpick #(
   parameter int N_SRC = 4,
   parameter int IW    = 2
) (
   input  logic [N_SRC-1:0] req,
   input  logic [IW-1:0]    last,
   output logic [IW-1:0]    pick,
   output logic             found
);

   logic [IW-1:0] idx;

   // The scan ends on 'last' itself, so the previous owner only wins when nobody else asks.
   always_comb begin
      // NOTE: every output gets a default before the loop, otherwise a latch is inferred.
      pick  = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 1; k <= N_SRC; k++) begin
         idx = IW'((int'(last) + k) % N_SRC);
         if (!found && req[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

endmodule

// File: rtl/led_arb.sv
// Round-robin arbiter time-sharing one LED bank between counter sources,
// with dwell windows counted in tick strobes and a blank between owners.
module led_arb
   import led_arb_pkg::*;
#(
   parameter  int N_SRC = 4,
   parameter  int WIDTH = 8,
   parameter  int DWELL = 4,
   localparam int IW    = cnt_width(N_SRC),
   localparam int DW    = cnt_width(DWELL)
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   tick,
   input  logic [N_SRC-1:0]       req,
   input  logic [N_SRC*WIDTH-1:0] src_data,
   input  logic                   lock,
   output logic [WIDTH-1:0]       leds,
   output logic [N_SRC-1:0]       grant,
   output logic [IW-1:0]          owner,
   output logic                   busy
);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] leds_nxt;
   logic [N_SRC-1:0] grant_nxt;
   logic [IW-1:0]    owner_nxt, pick;
   logic [DW-1:0]    dwell_cnt, dwell_nxt;
   logic             busy_nxt, found, expire, other_req;
   logic [WIDTH-1:0] src [N_SRC];

   for (genvar i = 0; i < N_SRC; i++) begin : g_src
      assign src[i] = src_data[i*WIDTH +: WIDTH];
   end

   led_arb_rrpick #(
      .N_SRC (N_SRC),
      .IW    (IW)
   ) u_pick (
      .req   (req),
      .last  (owner),
      .pick  (pick),
      .found (found)
   );

   assign expire    = tick && (dwell_cnt == DW'(DWELL - 1));
   assign other_req = |(req & ~grant);

   always_comb begin
      state_nxt = state;
      leds_nxt  = '0;
      grant_nxt = grant;
      owner_nxt = owner;
      busy_nxt  = busy;
      dwell_nxt = dwell_cnt;

      unique case (state)
         IDLE, HANDOFF: begin
            state_nxt = IDLE;
            grant_nxt = '0;
            busy_nxt  = 1'b0;
            dwell_nxt = '0;
            if (found) begin
               state_nxt = OWN;
               owner_nxt = pick;
               grant_nxt = N_SRC'(1) << pick;
               busy_nxt  = 1'b1;
            end
         end

         OWN: begin
            leds_nxt = src[owner];
            if (tick) dwell_nxt = expire ? '0 : dwell_cnt + DW'(1);
            // Release wins over expiry and lock; a lone owner keeps the bank unblanked.
            if (!req[owner] || (expire && !lock && other_req)) begin
               state_nxt = HANDOFF;
               grant_nxt = '0;
               busy_nxt  = 1'b0;
               dwell_nxt = '0;
            end
         end

         default: begin
            state_nxt = IDLE;
            grant_nxt = '0;
            busy_nxt  = 1'b0;
            dwell_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         leds      <= '0;
         grant     <= '0;
         owner     <= IW'(N_SRC - 1);
         busy      <= 1'b0;
         dwell_cnt <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state     <= state_nxt;
         leds      <= leds_nxt;
         grant     <= grant_nxt;
         owner     <= owner_nxt;
         busy      <= busy_nxt;
         dwell_cnt <= dwell_nxt;
      end
   end

endmodule

// File: tb/tb_led_arb.sv
// Scoreboard bench for led_arb: stimulus pushes model expectations, a monitor pops and compares each cycle.
module tb_led_arb;

   localparam int N     = 4;
   localparam int W     = 8;
   localparam int DWELL = 3;

   typedef struct {
      logic [W-1:0] leds;
      logic [N-1:0] grant;
      logic [1:0]   owner;
      logic         busy;
   } exp_t;

   logic           clk, rstn, tick, lock;
   logic [N-1:0]   req;
   logic [N*W-1:0] src_data;
   logic [W-1:0]   leds;
   logic [N-1:0]   grant;
   logic [1:0]     owner;
   logic           busy;

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t q[$];

   // Reference model: "is someone holding the bank, who, and how many ticks so far".
   int m_own, m_owner, m_ticks;

   led_arb #(
      .N_SRC (N),
      .WIDTH (W),
      .DWELL (DWELL)
   ) dut (
      .clk      (clk),
      .rstn     (rstn),
      .tick     (tick),
      .req      (req),
      .src_data (src_data),
      .lock     (lock),
      .leds     (leds),
      .grant    (grant),
      .owner    (owner),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int rr_next(input logic [N-1:0] r, input int last);
      for (int j = 1; j <= N; j++) begin
         if (r[(last + j) % N]) return (last + j) % N;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_own   = 0;
      m_owner = N - 1;
      m_ticks = 0;
   endtask

   // Drive one cycle of inputs and predict the outputs after the coming rising edge.
   task automatic drive_and_model(input logic [N-1:0] r, input logic t, input logic l);
      exp_t e;
      int   w;
      bit   expired, others;
      req  = r;
      tick = t;
      lock = l;
      for (int i = 0; i < N; i++) src_data[i*W +: W] = W'($urandom_range(1, (1 << W) - 1));
      e.leds = m_own ? src_data[m_owner*W +: W] : '0;
      if (m_own != 0) begin
         expired = 0;
         others  = 0;
         if (tick) begin
            m_ticks++;
            if (m_ticks == DWELL) begin
               expired = 1;
               m_ticks = 0;
            end
         end
         for (int j = 0; j < N; j++) if (j != m_owner && req[j]) others = 1;
         if (!req[m_owner] || (expired && !lock && others)) begin
            m_own   = 0;
            m_ticks = 0;
         end
      end else begin
         w = rr_next(req, m_owner);
         if (w >= 0) begin
            m_own   = 1;
            m_owner = w;
            m_ticks = 0;
         end
      end
      e.grant = m_own ? (N'(1) << m_owner) : '0;
      e.busy  = (m_own != 0);
      e.owner = 2'(m_owner);
      q.push_back(e);
   endtask

   task automatic step(input logic [N-1:0] r, input logic t, input logic l);
      @(negedge clk);
      drive_and_model(r, t, l);
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   // Monitor: outputs are valid every cycle; compare whatever the stimulus predicted.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            check("leds",  64'(leds),  64'(e.leds));
            check("grant", 64'(grant), 64'(e.grant));
            check("owner", 64'(owner), 64'(e.owner));
            check("busy",  64'(busy),  64'(e.busy));
         end
      end
   end

   initial begin
      logic [N-1:0] rr;
      rstn = 1'b0;
      req  = 4'b1010;
      tick = 1'b0;
      lock = 1'b0;
      src_data = '0;
      model_reset();

      // Reset with requests pending.
      repeat (2) @(posedge clk);
      #2;
      check("rst leds",  64'(leds),  64'(0));
      check("rst grant", 64'(grant), 64'(0));
      check("rst busy",  64'(busy),  64'(0));
      check("rst owner", 64'(owner), 64'(3));
      rstn = 1'b1;
      step(4'b1010, 1'b0, 1'b0);
      settle();
      check("first grant", 64'(grant), 64'(4'b0010));
      check("first owner", 64'(owner), 64'(1));
      check("first leds blank", 64'(leds), 64'(0));
      step(4'b1010, 1'b0, 1'b0);
      settle();
      check("first pattern", 64'(leds), 64'(src_data[15:8]));

      // Round robin with every source requesting.
      for (int i = 0; i < 64; i++) step(4'b1111, (i % 4) == 3, 1'b0);

      // Sole requester keeps the bank across expiries.
      for (int i = 0; i < 32; i++) step(4'b0100, (i % 4) == 3, 1'b0);
      settle();
      check("sole grant", 64'(grant), 64'(4'b0100));

      // Lock holds owner 0 for nine ticks, then release of lock hands off.
      for (int i = 0; i < 4; i++) step(4'b0001, 1'b0, 1'b0);
      for (int i = 0; i < 36; i++) step(4'b0011, (i % 4) == 3, 1'b1);
      settle();
      check("locked grant", 64'(grant), 64'(4'b0001));
      for (int i = 0; i < 16; i++) step(4'b0011, (i % 4) == 3, 1'b0);
      settle();
      check("unlock grant", 64'(grant), 64'(4'b0010));

      // Release on the same cycle as an expiring tick.
      for (int i = 0; i < 4; i++) step(4'b1000, 1'b0, 1'b0);
      step(4'b1001, 1'b0, 1'b0);
      for (int i = 0; i < DWELL && m_ticks != DWELL - 1; i++) step(4'b1001, 1'b1, 1'b0);
      step(4'b0001, 1'b1, 1'b0);
      settle();
      check("release handoff grant", 64'(grant), 64'(0));
      step(4'b0001, 1'b0, 1'b0);
      settle();
      check("release wrap grant", 64'(grant), 64'(4'b0001));

      // Asynchronous reset pulse between edges while owning.
      for (int i = 0; i < 6; i++) step(4'b0110, 1'b0, 1'b0);
      @(negedge clk);
      #1 rstn = 1'b0;
      #1;
      check("async leds",  64'(leds),  64'(0));
      check("async grant", 64'(grant), 64'(0));
      check("async busy",  64'(busy),  64'(0));
      check("async owner", 64'(owner), 64'(3));
      rstn = 1'b1;
      model_reset();
      drive_and_model(4'b0110, 1'b0, 1'b0);
      settle();
      check("post reset grant", 64'(grant), 64'(4'b0010));

      // Randomised traffic.
      rr = 4'($urandom);
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 5) == 0) rr = 4'($urandom);
         step(rr, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
      end

      repeat (2) @(posedge clk);
      #2;
      check("queue drained", 64'(q.size()), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
